// File: rtl/rr_pkt_arb_pkg.sv
// ============================================================================
// Module   : noc_arb_pkg
// Purpose  : Shared types and helpers for the round-robin packet arbiter.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package noc_arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    // All-ones code of width w, used as the "no grant" index
    function automatic logic [15:0] idle_idx(input int w);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < w) r[i] = 1'b1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_pkt_arb_pick.sv
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin pick: rotate by ptr, priority-encode,
//            rotate the result back to an absolute channel index.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pick
    import noc_arb_pkg::*;
#(
    parameter int N  = 5,
    parameter int IW = 3
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          any
);

    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_shift;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_enc;
    logic [IW:0]    w_sum;

    assign w_dbl   = {req, req};
    assign w_shift = w_dbl >> ptr;
    assign w_rot   = w_shift[N-1:0];
    assign any     = |req;

    always_comb begin
        w_enc = '0;
        // Descending scan so the lowest rotated position wins
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) w_enc = IW'(k);
        end
        w_sum = {1'b0, w_enc} + {1'b0, ptr};
        if (w_sum >= (IW + 1)'(N)) w_sum = w_sum - (IW + 1)'(N);
        idx = any ? w_sum[IW-1:0] : IW'(idle_idx(IW));
        gnt = any ? (N'(1) << w_sum) : '0;
    end

endmodule

`default_nettype wire

// File: rtl/rr_pkt_arb.sv
// ============================================================================
// Module   : rr_pkt_arb
// Purpose  : Round-robin packet arbiter for one NoC output port; holds each
//            grant for PKT_FLITS beats. Define RR_PKT_ARB_LOCK_TIMEOUT_EN for
//            the idle-lock timeout (adds LOCK_TMO and timeout_o).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_pkt_arb
    import noc_arb_pkg::*;
#(
    parameter int N_PORTS   = 5,
    parameter int PKT_FLITS = 5,
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
    parameter int LOCK_TMO  = 64,
`endif
    localparam int IDX_W    = $clog2(N_PORTS + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_PORTS-1:0] req_i,
    input  logic [N_PORTS-1:0] mask_i,
    input  logic               valid_i,
    output logic [N_PORTS-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic               busy_o,
    output logic               pkt_done_o
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
    ,
    output logic               timeout_o
`endif
);

    localparam int                c_cnt_w     = $clog2(PKT_FLITS + 1);
    localparam logic [c_cnt_w-1:0] c_last_flit = c_cnt_w'(PKT_FLITS - 1);
    localparam logic [IDX_W-1:0]   c_idle_idx  = IDX_W'(idle_idx(IDX_W));

    arb_state_e          r_state;
    logic [c_cnt_w-1:0]  r_flit_cnt;
    logic [IDX_W-1:0]    r_rr_ptr;

    logic [N_PORTS-1:0]  w_elig;
    logic [IDX_W-1:0]    w_next_ptr;
    logic [IDX_W-1:0]    w_pick_ptr;
    logic [N_PORTS-1:0]  w_pick_gnt;
    logic [IDX_W-1:0]    w_pick_idx;
    logic                w_pick_any;
    logic                w_last;
    logic                w_tmo_fire;

    assign w_elig     = req_i & ~mask_i;
    assign w_next_ptr = (grant_idx_o == IDX_W'(N_PORTS - 1)) ? '0 : grant_idx_o + 1'b1;
    // While locked the picker already looks from winner+1, giving zero-bubble handover
    assign w_pick_ptr = (r_state == ARB_LOCK) ? w_next_ptr : r_rr_ptr;
    assign w_last     = valid_i && (r_flit_cnt == c_last_flit);

`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
    localparam int                c_tmo_w    = $clog2(LOCK_TMO);
    localparam logic [c_tmo_w-1:0] c_tmo_last = c_tmo_w'(LOCK_TMO - 1);
    logic [c_tmo_w-1:0] r_tmo_cnt;
    assign w_tmo_fire = !valid_i && (r_tmo_cnt == c_tmo_last);
`else
    assign w_tmo_fire = 1'b0;
`endif

    rr_pick #(
        .N  (N_PORTS),
        .IW (IDX_W)
    ) u_pick (
        .req (w_elig),
        .ptr (w_pick_ptr),
        .gnt (w_pick_gnt),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ARB_IDLE;
            r_flit_cnt  <= '0;
            r_rr_ptr    <= '0;
            grant_o     <= '0;
            grant_idx_o <= c_idle_idx;
            busy_o      <= 1'b0;
            pkt_done_o  <= 1'b0;
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
            timeout_o   <= 1'b0;
            r_tmo_cnt   <= '0;
`endif
        end else begin
            pkt_done_o <= 1'b0;
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
            timeout_o  <= 1'b0;
`endif
            case (r_state)
                ARB_IDLE: begin
                    if (w_pick_any) begin
                        r_state     <= ARB_LOCK;
                        grant_o     <= w_pick_gnt;
                        grant_idx_o <= w_pick_idx;
                        busy_o      <= 1'b1;
                        r_flit_cnt  <= '0;
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
                        r_tmo_cnt   <= '0;
`endif
                    end
                end
                ARB_LOCK: begin
                    if (w_last || w_tmo_fire) begin
                        r_rr_ptr   <= w_next_ptr;
                        pkt_done_o <= w_last;
                        r_flit_cnt <= '0;
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
                        timeout_o  <= w_tmo_fire;
                        r_tmo_cnt  <= '0;
`endif
                        if (w_pick_any) begin
                            grant_o     <= w_pick_gnt;
                            grant_idx_o <= w_pick_idx;
                        end else begin
                            r_state     <= ARB_IDLE;
                            grant_o     <= '0;
                            grant_idx_o <= c_idle_idx;
                            busy_o      <= 1'b0;
                        end
                    end else begin
                        if (valid_i) r_flit_cnt <= r_flit_cnt + 1'b1;
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
                        r_tmo_cnt <= valid_i ? '0 : r_tmo_cnt + 1'b1;
`endif
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_rr_pkt_arb.sv
// ============================================================================
// Module   : tb_rr_pkt_arb
// Purpose  : Scoreboard bench for rr_pkt_arb (N_PORTS=5, PKT_FLITS=5).
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_rr_pkt_arb;

    localparam int EV_GRANT = 0;
    localparam int EV_DONE  = 1;
    localparam int EV_TMO   = 2;

    typedef struct {
        int kind;
        int idx;
        int cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] req = '0;
    logic [4:0] mask = '0;
    logic       valid = 1'b0;
    logic [4:0] grant;
    logic [2:0] grant_idx;
    logic       busy;
    logic       pkt_done;
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
    logic       timeout;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   mon_en = 1'b0;
    logic [2:0] prev_idx = 3'b111;
    ev_t  q[$];

    rr_pkt_arb #(
        .N_PORTS   (5),
        .PKT_FLITS (5)
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
        ,
        .LOCK_TMO  (4)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_i       (req),
        .mask_i      (mask),
        .valid_i     (valid),
        .grant_o     (grant),
        .grant_idx_o (grant_idx),
        .busy_o      (busy),
        .pkt_done_o  (pkt_done)
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
        ,
        .timeout_o   (timeout)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_ev(input int kind, input int idx, input int c);
        ev_t e;
        e.kind = kind;
        e.idx  = idx;
        e.cyc  = c;
        q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int idx);
        ev_t e;
        int  oh;
        if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got kind %0d idx %0d, expected none (cycle %0d)", kind, idx, cyc);
        end else begin
            e = q.pop_front();
            chk("event_kind", kind, e.kind);
            chk("event_cycle", cyc, e.cyc);
            if (kind == EV_GRANT && e.kind == EV_GRANT) begin
                oh = (e.idx == 7) ? 0 : (1 << e.idx);
                chk("grant_idx", idx, e.idx);
                chk("grant_onehot", int'(grant), oh);
                chk("busy", int'(busy), (e.idx == 7) ? 0 : 1);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every pulse and every grant change
    always @(negedge clk) begin
        if (mon_en) begin
            if (pkt_done) check_ev(EV_DONE, 0);
`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
            if (timeout) check_ev(EV_TMO, 0);
`endif
            if (grant_idx != prev_idx) check_ev(EV_GRANT, int'(grant_idx));
        end
        prev_idx = grant_idx;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [4:0] r, input logic [4:0] m, input logic v);
        req   = r;
        mask  = m;
        valid = v;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k;
        logic [7:0] pat;

        // Power-on reset values
        tick(2);
        chk("rst_grant", int'(grant), 0);
        chk("rst_idx", int'(grant_idx), 7);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(pkt_done), 0);
        rst = 1'b0;
        tick(1);
        mon_en = 1'b1;

        // Round robin over all ports, back to back
        drive(5'b11111, 5'b00000, 1'b1);
        k = cyc;
        for (int p = 0; p < 6; p++) begin
            if (p > 0) expect_ev(EV_DONE, 0, k + 1 + 5 * p);
            expect_ev(EV_GRANT, p % 5, k + 1 + 5 * p);
        end
        expect_ev(EV_DONE, 0, k + 31);
        expect_ev(EV_GRANT, 7, k + 31);
        tick(26);
        drive(5'b00000, 5'b00000, 1'b1);
        tick(5);
        drive(5'b00000, 5'b00000, 1'b0);
        tick(2);

        // Lock survives request drop and mask of the winner
        drive(5'b00100, 5'b00000, 1'b0);
        k = cyc;
        expect_ev(EV_GRANT, 2, k + 1);
        expect_ev(EV_DONE, 0, k + 6);
        expect_ev(EV_GRANT, 7, k + 6);
        tick(1);
        drive(5'b00000, 5'b00100, 1'b1);
        tick(2);
        chk("lock_hold_idx", int'(grant_idx), 2);
        chk("lock_hold_busy", int'(busy), 1);
        tick(3);
        drive(5'b00000, 5'b00000, 1'b0);
        tick(2);

        // Stalled valid pattern: release on the fifth beat
        drive(5'b00010, 5'b00000, 1'b0);
        k = cyc;
        expect_ev(EV_GRANT, 1, k + 1);
        expect_ev(EV_DONE, 0, k + 9);
        expect_ev(EV_GRANT, 7, k + 9);
        tick(1);
        req = 5'b00000;
        pat = 8'b11011001;
        for (int i = 0; i < 8; i++) begin
            valid = pat[i];
            tick(1);
            if (i == 6) chk("stall_hold_idx", int'(grant_idx), 1);
        end
        drive(5'b00000, 5'b00000, 1'b0);
        tick(2);

        // Asynchronous reset in the middle of a packet
        drive(5'b01000, 5'b00000, 1'b0);
        k = cyc;
        expect_ev(EV_GRANT, 3, k + 1);
        tick(1);
        valid = 1'b1;
        tick(1);
        chk("pre_rst_idx", int'(grant_idx), 3);
        chk("pre_rst_queue", q.size(), 0);
        mon_en = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_grant", int'(grant), 0);
        chk("async_rst_idx", int'(grant_idx), 7);
        chk("async_rst_busy", int'(busy), 0);
        chk("async_rst_done", int'(pkt_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(5'b00000, 5'b00000, 1'b0);
        tick(1);
        mon_en = 1'b1;

        // Mask at arbitration time, pointer back at 0
        drive(5'b00110, 5'b00010, 1'b0);
        k = cyc;
        expect_ev(EV_GRANT, 2, k + 1);
        expect_ev(EV_DONE, 0, k + 6);
        expect_ev(EV_GRANT, 1, k + 6);
        expect_ev(EV_DONE, 0, k + 11);
        expect_ev(EV_GRANT, 7, k + 11);
        tick(1);
        drive(5'b00110, 5'b00000, 1'b1);
        tick(5);
        drive(5'b00000, 5'b00000, 1'b1);
        tick(5);
        drive(5'b00000, 5'b00000, 1'b0);
        tick(2);

`ifdef RR_PKT_ARB_LOCK_TIMEOUT_EN
        // Forced release of an idle lock, handover to port 0
        drive(5'b10000, 5'b00000, 1'b0);
        k = cyc;
        expect_ev(EV_GRANT, 4, k + 1);
        expect_ev(EV_TMO, 0, k + 5);
        expect_ev(EV_GRANT, 0, k + 5);
        expect_ev(EV_TMO, 0, k + 9);
        expect_ev(EV_GRANT, 7, k + 9);
        tick(1);
        drive(5'b00001, 5'b00000, 1'b0);
        tick(4);
        drive(5'b00000, 5'b00000, 1'b0);
        tick(6);
`endif

        tick(2);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
